// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, stall freeze, flush squash
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int          n       = 32,
    parameter int          m       = 5,
    parameter int          C       = 8,
    parameter logic [31:0] CNT_RST = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    input  logic [m-1:0] id_rs1,
    input  logic [m-1:0] id_rs2,
    input  logic         id_use_rs1,
    input  logic         id_use_rs2,
    input  logic [m-1:0] id_rd,
    input  logic [n-1:0] id_rs1_data,
    input  logic [n-1:0] id_rs2_data,
    input  logic [n-1:0] id_imm,
    input  logic [n-1:0] id_pc,
    input  logic [C-1:0] id_ctrl,
    input  logic         mem_stall,
    input  logic         ex_flush,
    output logic         ID_EX_valid,
    output logic [m-1:0] ID_EX_rs1,
    output logic [m-1:0] ID_EX_rs2,
    output logic [m-1:0] ID_EX_rd,
    output logic [n-1:0] ID_EX_rs1_data,
    output logic [n-1:0] ID_EX_rs2_data,
    output logic [n-1:0] ID_EX_imm,
    output logic [n-1:0] ID_EX_pc,
    output logic [C-1:0] ID_EX_ctrl,
    output logic         hold_if_id,
    output logic [31:0]  bubble_count
);

    logic         valid_q, valid_d;
    logic [m-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [n-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [n-1:0] imm_q, imm_d, pc_q, pc_d;
    logic [C-1:0] ctrl_q, ctrl_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         hazard;

    // A load in EX whose rd feeds a real source read of the ID instruction.
    assign hazard = valid_q & ctrl_q[1] & (rd_q != '0) & id_valid &
                    ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));

    assign hold_if_id = ~rst & (mem_stall | (~ex_flush & hazard));

    always_comb begin
        valid_d    = valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;
        if (mem_stall) begin
            // frozen: everything keeps its value, a pending flush waits
        end else if (ex_flush || hazard) begin
            valid_d    = 1'b0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            pc_d       = '0;
            ctrl_d     = '0;
            if (!ex_flush && cnt_q != 32'hFFFF_FFFF)
                cnt_d = cnt_q + 32'd1;
        end else begin
            valid_d    = id_valid;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            pc_d       = id_pc;
            ctrl_d     = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            ctrl_q     <= '0;
            cnt_q      <= CNT_RST;
        end else begin
            valid_q    <= valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ID_EX_valid    = valid_q;
    assign ID_EX_rs1      = rs1_q;
    assign ID_EX_rs2      = rs2_q;
    assign ID_EX_rd       = rd_q;
    assign ID_EX_rs1_data = rs1_data_q;
    assign ID_EX_rs2_data = rs2_data_q;
    assign ID_EX_imm      = imm_q;
    assign ID_EX_pc       = pc_q;
    assign ID_EX_ctrl     = ctrl_q;
    assign bubble_count   = cnt_q;

endmodule
